// File: rtl/uart_rx_if.sv
// UART receiver handshake bundle: serial line in, byte stream out with
// valid/ready, plus the framing-error and overrun event pulses.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       frame_err;
    logic       overrun;

    // Line driver / byte consumer side
    modport master (
        output rx,
        output data_out_ready,
        input  data_out,
        input  data_out_valid,
        input  frame_err,
        input  overrun
    );

    // Receiver side
    modport slave (
        input  rx,
        input  data_out_ready,
        output data_out,
        output data_out_valid,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready output register.
// Optional build macro: UART_RX_MAJORITY_EN (3-sample majority vote per bit).
module uart_rx #(
    parameter int unsigned MAIN_CLK = 12000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    uart_rx_if.slave   bus
);

    localparam int unsigned CPB = MAIN_CLK / BAUD;
    localparam int unsigned CW  = $clog2(CPB + 1);

`ifdef UART_RX_MAJORITY_EN
    // Decision lands one clock after mid-bit so the third vote is available.
    localparam logic [CW-1:0] START_LOAD = CW'(CPB / 2);
`else
    localparam logic [CW-1:0] START_LOAD = CW'(CPB / 2 - 1);
`endif
    localparam logic [CW-1:0] BIT_LOAD = CW'(CPB - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_rx_meta;
    logic            r_rx_sync;
    logic [CW-1:0]   r_clk_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_data_out;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overrun;
    logic            w_tick;
    logic            w_bit;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0]      r_hist;

    // Majority of the current synchronized sample and the two before it
    always_comb begin
        w_bit = (r_rx_sync & r_hist[0]) | (r_rx_sync & r_hist[1]) | (r_hist[0] & r_hist[1]);
    end
`else
    // Single mid-bit sample
    always_comb begin
        w_bit = r_rx_sync;
    end
`endif

    assign bus.data_out       = r_data_out;
    assign bus.data_out_valid = r_valid;
    assign bus.frame_err      = r_frame_err;
    assign bus.overrun        = r_overrun;

    // Sample point reached when the bit-timing counter has run down
    always_comb begin
        w_tick = (r_clk_cnt == '0);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (!r_rx_sync) w_state_next = ST_START;
            ST_START: if (w_tick) w_state_next = w_bit ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_tick && (r_bit_cnt == 3'd7)) w_state_next = ST_STOP;
            ST_STOP:  if (w_tick) w_state_next = w_bit ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (r_rx_sync) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Synchronizer, bit timing, shift register and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            r_hist      <= '1;
`endif
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_meta   <= bus.rx;
            r_rx_sync   <= r_rx_meta;
`ifdef UART_RX_MAJORITY_EN
            r_hist      <= {r_hist[0], r_rx_sync};
`endif
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            if (r_valid && bus.data_out_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= '0;
                    r_clk_cnt <= START_LOAD;
                end
                ST_START: begin
                    r_clk_cnt <= w_tick ? BIT_LOAD : r_clk_cnt - CW'(1);
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_clk_cnt <= BIT_LOAD;
                    end else begin
                        r_clk_cnt <= r_clk_cnt - CW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_clk_cnt <= '0;
                        if (w_bit) begin
                            if (!r_valid || bus.data_out_ready) begin
                                r_data_out <= r_shift;
                                r_valid    <= 1'b1;
                            end else begin
                                r_overrun  <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt - CW'(1);
                    end
                end
                ST_BREAK: begin
                    r_clk_cnt <= '0;
                end
                default: begin
                    r_clk_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: Parameter MAIN_CLK, default 12000000, clk frequency in Hz.
- REQ-002: Parameter BAUD, default 115200, line bit rate; CLKS_PER_BIT = MAIN_CLK/BAUD (integer division) SHALL be >= 2, or >= 4 with UART_RX_MAJORITY_EN.
- REQ-003: clk  input  1  sole clock; all logic on rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
- REQ-006: data_out  output  8  received byte, stable while data_out_valid is high.
- REQ-007: data_out_valid  output  1  byte available.
- REQ-008: data_out_ready  input  1  consumer accepts; transfer when valid && ready on a rising edge.
- REQ-009: frame_err  output  1  one-cycle pulse, stop bit sampled low.
- REQ-010: overrun  output  1  one-cycle pulse, good byte dropped because the output register was full.

Function
- REQ-011: rx SHALL pass a 2-flop synchronizer (reset value 1); all decisions SHALL use the synchronized value only.
- REQ-012: FSM states are IDLE, START, DATA, STOP and BREAK; the FSM resets to IDLE.
- REQ-013: IDLE -> START when synchronized rx = 0; bit counter cleared; clock counter loaded for half a bit.
- REQ-014: START: after CLKS_PER_BIT/2 clocks, sample; 0 -> DATA with counter reloaded to CLKS_PER_BIT; 1 -> IDLE (glitch), no pulse, no output.
- REQ-015: DATA: 8 samples, each CLKS_PER_BIT clocks apart, shifted in LSB first; after the 8th sample -> STOP.
- REQ-016: STOP: sample CLKS_PER_BIT clocks after the last data sample; 1 -> deliver byte (REQ-018) and go to IDLE; 0 -> frame_err pulse, byte discarded, go to BREAK.
- REQ-017: BREAK: remain until synchronized rx = 1, then IDLE; no new start is detected in BREAK.
- REQ-018: Delivery: if output register empty, or data_out_ready high in the same cycle, then data_out <= byte and data_out_valid = 1 on the next cycle; otherwise overrun pulse, byte dropped, held data_out unchanged.
- REQ-019: data_out_valid SHALL stay high and data_out stable until a valid && ready transfer; it clears the cycle after transfer unless a new byte loads in the same cycle (REQ-018).
- REQ-020: Latency: data_out_valid asserts exactly 1 clk after the stop-bit sample edge.
- REQ-021: Back-to-back frames: a start bit immediately after a good stop bit SHALL be detected (IDLE reached at mid-stop, before the next falling edge).
- REQ-022: frame_err and overrun SHALL never be high for more than one consecutive cycle per event and never simultaneously.

Reset
- REQ-023: On rst = 1 at a clk edge: FSM = IDLE, counters = 0, shift register = 0, synchronizer = 1, data_out = 8'h00, data_out_valid = 0, frame_err = 0, overrun = 0.
- REQ-024: rst mid-frame SHALL abort the frame with no output or pulse; reception resumes at the next falling edge after rst deasserts.

Configuration
- REQ-025: Macro UART_RX_MAJORITY_EN defined: each start, data and stop sample is the majority of 3 synchronized samples taken at mid-bit-1, mid-bit and mid-bit+1 clocks; decision timing per REQ-014..016 is unchanged (decision at mid-bit+1, one clk later than without the macro, so REQ-020 latency is counted from that edge).
- REQ-026: Macro UART_RX_MAJORITY_EN undefined: single sample at mid-bit; no majority logic synthesized.

Verification (MAIN_CLK=16, BAUD=1, CLKS_PER_BIT=16, data_out_ready tied 1 unless stated)
- REQ-027: Send 8'h03, 8'h76, 8'h48 back-to-back -> three transfers with data_out 03, 76, 48, no frame_err or overrun.
- REQ-028: rx low for 4 clks, then high -> no data_out_valid, no pulse, FSM back in IDLE; following frame 8'hA5 is received correctly.
- REQ-029: Frame 8'hFF with stop bit driven 0, line held low for 40 clks -> exactly one frame_err pulse, no data_out_valid; next frame 8'h55 is received correctly after line returns high.
- REQ-030: data_out_ready = 0, send 8'hDE then 8'hAD -> data_out = DE held valid, one overrun pulse at 2nd stop sample; raising ready transfers DE only.
- REQ-031: Assert rst during bit 4 of frame 8'hAA -> no output or pulse; outputs at reset values; next frame 8'h5A is received correctly.
- REQ-032: With UART_RX_MAJORITY_EN, frame 8'h0F with one-clk glitches inverting the mid-bit sample of every bit -> data_out = 0F, no frame_err.
